// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the synth voice scheduler
package synth_pkg;

    localparam int SAMPLE_W_DEF   = 16;
    localparam int NUM_VOICES_DEF = 8;

    // Voice-select width; a single-bit select is kept even for degenerate voice counts
    function automatic int vsel_width(input int nv);
        return (nv > 1) ? $clog2(nv) : 1;
    endfunction

    localparam int VSEL_W = vsel_width(NUM_VOICES_DEF);
    localparam int ACC_W  = SAMPLE_W_DEF + VSEL_W;

    localparam logic [SAMPLE_W_DEF-1:0] SAT_MAX = {1'b0, {(SAMPLE_W_DEF-1){1'b1}}};
    localparam logic [SAMPLE_W_DEF-1:0] SAT_MIN = {1'b1, {(SAMPLE_W_DEF-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WAIT,
        SAT,
        OUT
    } voice_sched_state_t;

endpackage

// File: rtl/voice_mix_scheduler_saturate.sv
// rtl/voice_mix_scheduler_saturate.sv - combinational signed clamp from accumulator width to sample width
module mix_saturate
    import synth_pkg::*;
#(
    parameter int ACC_W_P    = ACC_W,
    parameter int SAMPLE_W_P = SAMPLE_W_DEF
) (
    input  logic signed [ACC_W_P-1:0]    acc_in,
    output logic        [SAMPLE_W_P-1:0] sat_out
);

    localparam logic signed [ACC_W_P-1:0] HI =
        {{(ACC_W_P-SAMPLE_W_P+1){1'b0}}, {(SAMPLE_W_P-1){1'b1}}};
    localparam logic signed [ACC_W_P-1:0] LO =
        {{(ACC_W_P-SAMPLE_W_P+1){1'b1}}, {(SAMPLE_W_P-1){1'b0}}};

    always_comb begin
        sat_out = acc_in[SAMPLE_W_P-1:0];
        if (acc_in > HI) begin
            sat_out = HI[SAMPLE_W_P-1:0];
        end else if (acc_in < LO) begin
            sat_out = LO[SAMPLE_W_P-1:0];
        end
    end

endmodule

// File: rtl/voice_mix_scheduler.sv
// rtl/voice_mix_scheduler.sv - per-sample voice sequencer and saturating mixer
// Optional OVERRUN_CNT output enabled by SAMPLE_OVERRUN_COUNT_EN.
module voice_mix_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = 8,
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                              CLK_50MHZ,
    input  logic                              RST,
    input  logic                              SAMPLE_TICK,
    input  logic [NUM_VOICES-1:0]             VOICE_EN,
    output logic                              VOICE_REQ,
    output logic [vsel_width(NUM_VOICES)-1:0] VOICE_SEL,
    input  logic                              VOICE_ACK,
    input  logic [SAMPLE_W-1:0]               VOICE_DATA,
    output logic [SAMPLE_W-1:0]               MIX_OUT,
    output logic                              MIX_VALID,
    output logic                              BUSY,
    output logic                              TIMEOUT,
`ifdef SAMPLE_OVERRUN_COUNT_EN
    output logic                              OVERRUN,
    output logic [15:0]                       OVERRUN_CNT
`else
    output logic                              OVERRUN
`endif
);

    localparam int SEL_W = vsel_width(NUM_VOICES);
    localparam int AW    = SAMPLE_W + SEL_W;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    voice_sched_state_t     state_q, state_d;
    logic [SEL_W-1:0]       idx_q, idx_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [NUM_VOICES-1:0]  en_q, en_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   req_q, req_d;
    logic [SAMPLE_W-1:0]    mix_q, mix_d;
    logic                   mix_valid_q, mix_valid_d;
    logic                   timeout_q, timeout_d;
    logic                   overrun_q, overrun_d;
    logic [SAMPLE_W-1:0]    sat_val;
    logic signed [AW-1:0]   data_ext;
    logic                   last_idx;

    assign data_ext = {{SEL_W{VOICE_DATA[SAMPLE_W-1]}}, VOICE_DATA};
    assign last_idx = (idx_q == SEL_W'(NUM_VOICES - 1));

    mix_saturate #(
        .ACC_W_P    (AW),
        .SAMPLE_W_P (SAMPLE_W)
    ) u_sat (
        .acc_in  (acc_q),
        .sat_out (sat_val)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        en_d        = en_q;
        tmo_cnt_d   = tmo_cnt_q;
        req_d       = req_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = SAMPLE_TICK && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (SAMPLE_TICK) begin
                    en_d    = VOICE_EN;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (en_q[idx_q]) begin
                    req_d     = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = WAIT;
                end else if (last_idx) begin
                    state_d = SAT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WAIT: begin
                // A timed-out voice contributes nothing but advances exactly like an ack
                if (VOICE_ACK || (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1))) begin
                    if (VOICE_ACK) begin
                        acc_d = acc_q + data_ext;
                    end else begin
                        timeout_d = 1'b1;
                    end
                    req_d = 1'b0;
                    if (last_idx) begin
                        state_d = SAT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            SAT: begin
                mix_d       = sat_val;
                mix_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            en_q        <= '0;
            tmo_cnt_q   <= '0;
            req_q       <= 1'b0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            en_q        <= en_d;
            tmo_cnt_q   <= tmo_cnt_d;
            req_q       <= req_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign VOICE_REQ = req_q;
    assign VOICE_SEL = idx_q;
    assign MIX_OUT   = mix_q;
    assign MIX_VALID = mix_valid_q;
    assign BUSY      = (state_q != IDLE);
    assign TIMEOUT   = timeout_q;
    assign OVERRUN   = overrun_q;

`ifdef SAMPLE_OVERRUN_COUNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic [16:0] ovr_sum;

    // Counts pulses as they are produced, so it moves in the same cycle the pulses appear
    assign ovr_sum = {1'b0, ovr_cnt_q} + {16'd0, overrun_d} + {16'd0, timeout_d};

    always_comb begin
        ovr_cnt_d = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign OVERRUN_CNT = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// tb/tb_voice_mix_scheduler.sv - self-checking bench for voice_mix_scheduler against a frame-level model
module tb_voice_mix_scheduler;

    localparam int NV  = 8;
    localparam int SW  = 16;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [NV-1:0] en = '0;
    logic          ack = 1'b0;
    logic [SW-1:0] data = '0;
    logic          req;
    logic [2:0]    sel;
    logic [SW-1:0] mix_out;
    logic          mix_valid;
    logic          busy;
    logic          timeout;
    logic          overrun;
`ifdef SAMPLE_OVERRUN_COUNT_EN
    logic [15:0]   ovr_cnt;
    int            exp_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;

    int                   lat[NV];
    logic signed [SW-1:0] dat[NV];

    always #5 clk = ~clk;

    voice_mix_scheduler #(
        .NUM_VOICES  (NV),
        .SAMPLE_W    (SW),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .CLK_50MHZ   (clk),
        .RST         (rst),
        .SAMPLE_TICK (tick),
        .VOICE_EN    (en),
        .VOICE_REQ   (req),
        .VOICE_SEL   (sel),
        .VOICE_ACK   (ack),
        .VOICE_DATA  (data),
        .MIX_OUT     (mix_out),
        .MIX_VALID   (mix_valid),
        .BUSY        (busy),
        .TIMEOUT     (timeout),
`ifdef SAMPLE_OVERRUN_COUNT_EN
        .OVERRUN     (overrun),
        .OVERRUN_CNT (ovr_cnt)
`else
        .OVERRUN     (overrun)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: the model derives visit order, mix, finish cycle and pulse counts from the rules,
    // while the loop plays the voices and randomly toggles VOICE_EN and stray ACKs.
    task automatic run_frame(input string tag, input logic [NV-1:0] en_v, input int ovr_at);
        int            exp_sum = 0;
        int            exp_cyc = NV + 2;
        int            exp_tmo = 0;
        int            exp_req = 0;
        int            exp_ovr;
        int            ovr_cyc;
        int            n_valid = 0;
        int            first_valid = -1;
        int            n_tmo = 0;
        int            n_ovr = 0;
        int            n_req = 0;
        int            age = 0;
        int            cur = 0;
        logic          prev_req = 1'b0;
        logic [SW-1:0] exp_mix;
        logic [SW-1:0] got_mix = '0;
        int            vq[$];

        for (int v = 0; v < NV; v++) begin
            if (en_v[v]) begin
                vq.push_back(v);
                exp_req++;
                if (lat[v] >= 0 && lat[v] < TMO) begin
                    exp_sum += int'(dat[v]);
                    exp_cyc += lat[v] + 1;
                end else begin
                    exp_tmo++;
                    exp_cyc += TMO;
                end
            end
        end
        if (exp_sum > 32767) exp_sum = 32767;
        if (exp_sum < -32768) exp_sum = -32768;
        exp_mix = SW'(exp_sum);
        ovr_cyc = (ovr_at == 999) ? exp_cyc : ovr_at;
        exp_ovr = (ovr_cyc >= 1 && ovr_cyc <= exp_cyc) ? 1 : 0;

        en   = en_v;
        tick = 1'b1;
        ack  = 1'b0;
        for (int c = 1; c <= exp_cyc + 3; c++) begin
            step();
            tick = (c == ovr_cyc);
            en   = NV'($urandom);
            if (mix_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = c;
                got_mix = mix_out;
            end
            n_tmo += int'(timeout);
            n_ovr += int'(overrun);
            if (req) begin
                if (!prev_req) begin
                    n_req++;
                    age = 0;
                    cur = int'(sel);
                    if (vq.size() > 0) chk({tag, " sel_order"}, 32'(sel), 32'(vq.pop_front()));
                end else begin
                    age++;
                    chk({tag, " sel_stable"}, 32'(sel), 32'(cur));
                end
                ack  = (lat[cur] == age);
                data = ack ? dat[cur] : SW'($urandom);
            end else begin
                ack  = ($urandom_range(0, 3) == 0);
                data = SW'($urandom);
            end
            prev_req = req;
        end
        tick = 1'b0;
        ack  = 1'b0;

        chk({tag, " req_count"},   32'(n_req),       32'(exp_req));
        chk({tag, " valid_count"}, 32'(n_valid),     32'd1);
        chk({tag, " valid_cycle"}, 32'(first_valid), 32'(exp_cyc));
        chk({tag, " mix_out"},     32'(got_mix),     32'(exp_mix));
        chk({tag, " mix_hold"},    32'(mix_out),     32'(exp_mix));
        chk({tag, " timeouts"},    32'(n_tmo),       32'(exp_tmo));
        chk({tag, " overruns"},    32'(n_ovr),       32'(exp_ovr));
        chk({tag, " idle_after"},  32'(busy),        32'd0);
`ifdef SAMPLE_OVERRUN_COUNT_EN
        exp_cnt += exp_tmo + exp_ovr;
        if (exp_cnt > 65535) exp_cnt = 65535;
        chk({tag, " ovr_cnt"}, 32'(ovr_cnt), 32'(exp_cnt));
`endif
    endtask

    initial begin
        int n_bad;
        int r;
        int ovr_at;

        rst = 1'b1;
        repeat (3) step();
        chk("rst req",       32'(req),       32'd0);
        chk("rst sel",       32'(sel),       32'd0);
        chk("rst mix_out",   32'(mix_out),   32'd0);
        chk("rst mix_valid", 32'(mix_valid), 32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst timeout",   32'(timeout),   32'd0);
        chk("rst overrun",   32'(overrun),   32'd0);
`ifdef SAMPLE_OVERRUN_COUNT_EN
        chk("rst ovr_cnt",   32'(ovr_cnt),   32'd0);
`endif
        rst = 1'b0;
        step();

        for (int v = 0; v < NV; v++) begin
            lat[v] = 2;
            dat[v] = '0;
        end
        run_frame("none_enabled", 8'h00, -1);

        dat[0] = 16'sd1000;
        dat[3] = -16'sd300;
        run_frame("voices_0_3", 8'b0000_1001, -1);

        for (int v = 0; v < NV; v++) begin
            lat[v] = $urandom_range(0, 5);
            dat[v] = 16'sh7FFF;
        end
        run_frame("pos_sat", 8'hFF, -1);

        for (int v = 0; v < NV; v++) dat[v] = 16'sh8000;
        run_frame("neg_sat", 8'hFF, -1);

        for (int v = 0; v < NV; v++) begin
            lat[v] = $urandom_range(0, 4);
            dat[v] = SW'($urandom_range(0, 4000)) - 16'sd2000;
        end
        lat[2] = -1;
        run_frame("voice2_timeout", 8'hFF, -1);

        lat[1] = TMO - 1;
        lat[2] = 3;
        lat[5] = TMO;
        run_frame("ack_edge", 8'b0010_0110, -1);

        // Reset in the middle of a WAIT aborts the frame with no mix produced
        lat[2] = -1;
        en     = 8'h04;
        tick   = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 20 && !req; i++) step();
        chk("rstmid req_seen", 32'(req), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rstmid req",       32'(req),       32'd0);
        chk("rstmid busy",      32'(busy),      32'd0);
        chk("rstmid mix_valid", 32'(mix_valid), 32'd0);
        rst = 1'b0;
        n_bad = 0;
        repeat (80) begin
            step();
            n_bad += int'(mix_valid) + int'(timeout) + int'(busy);
        end
        chk("rstmid quiet", 32'(n_bad), 32'd0);
`ifdef SAMPLE_OVERRUN_COUNT_EN
        exp_cnt = 0;
`endif

        for (int v = 0; v < NV; v++) lat[v] = 3;
        run_frame("overrun_wait", 8'h01, 3);
        run_frame("overrun_out", 8'h10, 999);

        for (int f = 0; f < 20; f++) begin
            for (int v = 0; v < NV; v++) begin
                r = $urandom_range(0, 9);
                lat[v] = (r == 0) ? -1 : (r == 1) ? TMO - 1 : int'($urandom_range(0, 6));
                dat[v] = SW'($urandom);
            end
            ovr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
            run_frame($sformatf("rand%0d", f), NV'($urandom), ovr_at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
